// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Control FSM for a multi-cycle RV32I datapath. It walks each instruction
//   through fetch/decode/execute/memory/writeback so that a single ALU and a
//   single memory port can be shared. It stalls on MEM_READY, halts for good
//   on an illegal opcode, and counts retired instructions.
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   OPCODE, FUNCT3    fields of the held instruction register
//   ZERO              ALU zero flag, used by BEQ/BNE
//   MEM_READY         memory finishes the current access this cycle
//   MEM_EN/MEM_RW     memory request, 0 read / 1 write
//   IORD              memory address select: 0 PC, 1 ALUOut
//   IR_WE, PC_WE      instruction register / PC load strobes
//   PC_SRC            PC source: 0 ALU result, 1 ALUOut
//   ALU_SRC_A/B, ALU_OP  ALU operand and operation selects
//   REG_WE, MEMTOREG  register file write enable and writeback source
//   STATE             current state (debug)
//   ILLEGAL           sticky illegal-opcode flag
//   RETIRED           retired-instruction counter, wraps
//
// state    | meaning
// ---------+----------------------------------------------
// IDLE     | after reset, everything quiet
// FETCH    | read instruction at PC, PC+4 computed by ALU
// DECODE   | branch target (OLD_PC + imm) into ALUOut
// EXEC_R   | RD1 op RD2
// EXEC_I   | RD1 op imm
// MEM_ADDR | RD1 + imm -> effective address
// MEM_RD   | load access, wait for MEM_READY
// MEM_WR   | store access, wait for MEM_READY, then retire
// WB_ALU   | ALUOut -> register file, retire
// WB_MEM   | MDR -> register file, retire
// BRANCH   | RD1 - RD2, PC <= ALUOut when taken, retire
// HALT     | illegal opcode, stuck until reset
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [6:0]       OPCODE,
  input  logic [2:0]       FUNCT3,
  input  logic             ZERO,
  input  logic             MEM_READY,
  output logic             MEM_EN,
  output logic             MEM_RW,
  output logic             IORD,
  output logic             IR_WE,
  output logic             PC_WE,
  output logic             PC_SRC,
  output logic [1:0]       ALU_SRC_A,
  output logic [1:0]       ALU_SRC_B,
  output logic [1:0]       ALU_OP,
  output logic             REG_WE,
  output logic             MEMTOREG,
  output logic [3:0]       STATE,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] RETIRED
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  state_t state;
  state_t state_nxt;
  logic   retire;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    MEM_EN    = 1'b0;
    MEM_RW    = 1'b0;
    IORD      = 1'b0;
    IR_WE     = 1'b0;
    PC_WE     = 1'b0;
    PC_SRC    = 1'b0;
    ALU_SRC_A = 2'd0;
    ALU_SRC_B = 2'd0;
    ALU_OP    = 2'b00;
    REG_WE    = 1'b0;
    MEMTOREG  = 1'b0;

    case (state)
      S_IDLE: state_nxt = S_FETCH;

      S_FETCH: begin
        MEM_EN    = 1'b1;
        ALU_SRC_B = 2'd2;
        IR_WE     = MEM_READY;
        PC_WE     = MEM_READY;
        if (MEM_READY) state_nxt = S_DECODE;
      end

      S_DECODE: begin
        ALU_SRC_A = 2'd2;
        ALU_SRC_B = 2'd1;
        case (OPCODE)
          OP_R:         state_nxt = S_EXEC_R;
          OP_I:         state_nxt = S_EXEC_I;
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_BR:        state_nxt = (FUNCT3[2:1] == 2'b00) ? S_BRANCH : S_HALT;
          default:      state_nxt = S_HALT;
        endcase
      end

      S_EXEC_R: begin
        ALU_SRC_A = 2'd1;
        ALU_SRC_B = 2'd0;
        ALU_OP    = 2'b10;
        state_nxt = S_WB_ALU;
      end

      S_EXEC_I: begin
        ALU_SRC_A = 2'd1;
        ALU_SRC_B = 2'd1;
        ALU_OP    = 2'b11;
        state_nxt = S_WB_ALU;
      end

      S_MEM_ADDR: begin
        ALU_SRC_A = 2'd1;
        ALU_SRC_B = 2'd1;
        // IR is still holding the instruction, so OPCODE picks load vs store
        state_nxt = (OPCODE == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        MEM_EN = 1'b1;
        IORD   = 1'b1;
        if (MEM_READY) state_nxt = S_WB_MEM;
      end

      S_MEM_WR: begin
        MEM_EN = 1'b1;
        MEM_RW = 1'b1;
        IORD   = 1'b1;
        if (MEM_READY) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end
      end

      S_WB_ALU: begin
        REG_WE    = 1'b1;
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end

      S_WB_MEM: begin
        REG_WE    = 1'b1;
        MEMTOREG  = 1'b1;
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end

      S_BRANCH: begin
        ALU_SRC_A = 2'd1;
        ALU_SRC_B = 2'd0;
        ALU_OP    = 2'b01;
        PC_SRC    = 1'b1;
        // FUNCT3[0] distinguishes BNE from BEQ
        PC_WE     = ZERO ^ FUNCT3[0];
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end

      S_HALT: state_nxt = S_HALT;

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ILLEGAL <= 1'b0;
      RETIRED <= '0;
    end else begin
      if (state == S_DECODE && state_nxt == S_HALT) ILLEGAL <= 1'b1;
      if (retire) RETIRED <= RETIRED + CNT_W'(1);
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
//   Random instruction streams for multicycle_ctrl (CNT_W=4 so the retire
//   counter wraps). The driver builds each instruction's expected state trace
//   from its class and stall counts, pushes it to a queue and plays the
//   matching MEM_READY pattern; the monitor pops and compares every cycle.
module tb_multicycle_ctrl;

  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [6:0]    OPCODE;
  logic [2:0]    FUNCT3;
  logic          ZERO;
  logic          MEM_READY;
  logic          MEM_EN, MEM_RW, IORD, IR_WE, PC_WE, PC_SRC;
  logic [1:0]    ALU_SRC_A, ALU_SRC_B, ALU_OP;
  logic          REG_WE, MEMTOREG;
  logic [3:0]    STATE;
  logic          ILLEGAL;
  logic [CW-1:0] RETIRED;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNCT3(FUNCT3), .ZERO(ZERO),
    .MEM_READY(MEM_READY), .MEM_EN(MEM_EN), .MEM_RW(MEM_RW), .IORD(IORD),
    .IR_WE(IR_WE), .PC_WE(PC_WE), .PC_SRC(PC_SRC), .ALU_SRC_A(ALU_SRC_A),
    .ALU_SRC_B(ALU_SRC_B), .ALU_OP(ALU_OP), .REG_WE(REG_WE),
    .MEMTOREG(MEMTOREG), .STATE(STATE), .ILLEGAL(ILLEGAL), .RETIRED(RETIRED)
  );

  always #5 CLK = ~CLK;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef struct {
    int            len;
    logic [127:0]  st;   // 4 bits per cycle
    logic [31:0]   mr;   // MEM_READY per cycle
    logic [6:0]    op;
    logic [2:0]    f3;
    logic          zero;
    logic [CW-1:0] ret;  // RETIRED while this instruction is in flight
  } item_t;

  item_t         q[$];
  int            checks   = 0;
  int            failures = 0;
  logic [CW-1:0] ret_model = '0;

  wire [14:0] dut_ctrl = {MEM_EN, MEM_RW, IORD, IR_WE, PC_WE, PC_SRC,
                          ALU_SRC_A, ALU_SRC_B, ALU_OP, REG_WE, MEMTOREG};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // control word each state must present, straight from the state table
  function automatic logic [14:0] exp_ctrl(input logic [3:0] s, input logic mr,
                                           input logic z, input logic [2:0] f3);
    logic en, rw, iord, irwe, pcwe, pcsrc, rwe, m2r;
    logic [1:0] sa, sb, op;
    {en, rw, iord, irwe, pcwe, pcsrc, rwe, m2r} = '0;
    sa = 2'd0; sb = 2'd0; op = 2'd0;
    case (s)
      4'd1:  begin en = 1; sb = 2; irwe = mr; pcwe = mr; end
      4'd2:  begin sa = 2; sb = 1; end
      4'd3:  begin sa = 1; sb = 0; op = 2'b10; end
      4'd4:  begin sa = 1; sb = 1; op = 2'b11; end
      4'd5:  begin sa = 1; sb = 1; end
      4'd6:  begin en = 1; iord = 1; end
      4'd7:  begin en = 1; rw = 1; iord = 1; end
      4'd8:  rwe = 1;
      4'd9:  begin rwe = 1; m2r = 1; end
      4'd10: begin sa = 1; sb = 0; op = 2'b01; pcsrc = 1; pcwe = z ^ f3[0]; end
      default: ;
    endcase
    return {en, rw, iord, irwe, pcwe, pcsrc, sa, sb, op, rwe, m2r};
  endfunction

  function automatic item_t add(input item_t it, input logic [3:0] s, input logic m);
    item_t r = it;
    r.st[r.len*4 +: 4] = s;
    r.mr[r.len]        = m;
    r.len++;
    return r;
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op == OP_R || op == OP_I || op == OP_LW || op == OP_SW || op == OP_BR;
  endfunction

  // cls: 0 R, 1 I, 2 LW, 3 SW, 4 BEQ, 5 BNE, 6 illegal
  function automatic item_t build(input int cls, input int fs, input int ms, input int nh);
    item_t it;
    it.len  = 0;
    it.st   = '0;
    it.mr   = '0;
    it.zero = 1'($urandom_range(0, 1));
    it.f3   = 3'($urandom_range(0, 7));
    it.ret  = ret_model;
    it.op   = OP_R;
    for (int k = 0; k < fs; k++) it = add(it, 4'd1, 1'b0);
    it = add(it, 4'd1, 1'b1);
    it = add(it, 4'd2, 1'($urandom_range(0, 1)));
    case (cls)
      0: begin it.op = OP_R; it = add(it, 4'd3, 1'($urandom_range(0, 1)));
               it = add(it, 4'd8, 1'($urandom_range(0, 1))); end
      1: begin it.op = OP_I; it = add(it, 4'd4, 1'($urandom_range(0, 1)));
               it = add(it, 4'd8, 1'($urandom_range(0, 1))); end
      2: begin
        it.op = OP_LW; it.f3 = 3'b010;
        it = add(it, 4'd5, 1'($urandom_range(0, 1)));
        for (int k = 0; k < ms; k++) it = add(it, 4'd6, 1'b0);
        it = add(it, 4'd6, 1'b1);
        it = add(it, 4'd9, 1'($urandom_range(0, 1)));
      end
      3: begin
        it.op = OP_SW; it.f3 = 3'b010;
        it = add(it, 4'd5, 1'($urandom_range(0, 1)));
        for (int k = 0; k < ms; k++) it = add(it, 4'd7, 1'b0);
        it = add(it, 4'd7, 1'b1);
      end
      4: begin it.op = OP_BR; it.f3 = 3'b000; it = add(it, 4'd10, 1'($urandom_range(0, 1))); end
      5: begin it.op = OP_BR; it.f3 = 3'b001; it = add(it, 4'd10, 1'($urandom_range(0, 1))); end
      default: begin
        case ($urandom_range(0, 2))
          0: it.op = 7'h7F;
          1: begin it.op = OP_BR; it.f3 = 3'($urandom_range(2, 7)); end
          default: begin
            it.op = 7'($urandom);
            while (is_legal(it.op)) it.op = 7'($urandom);
          end
        endcase
        for (int k = 0; k < nh; k++) it = add(it, 4'd15, 1'($urandom_range(0, 1)));
      end
    endcase
    return it;
  endfunction

  // Entered at posedge+1 of the item's first cycle. With adv the driver ends
  // at posedge+1 of the following cycle, otherwise inside the last cycle.
  task automatic run_item(input item_t it, input bit adv);
    q.push_back(it);
    for (int i = 0; i < it.len; i++) begin
      OPCODE    = it.op;
      FUNCT3    = it.f3;
      ZERO      = it.zero;
      MEM_READY = it.mr[i];
      if (i < it.len - 1 || adv) begin
        @(posedge CLK); #1;
      end
    end
    if (adv) ret_model = ret_model + 1'b1;
  endtask

  task automatic do_reset();
    @(negedge CLK); #1;
    RST = 1'b1;
    MEM_READY = 1'b0;
    #1;
    chk("rst_state",    32'(STATE),   32'd0);
    chk("rst_ctrl",     32'(dut_ctrl), 32'd0);
    chk("rst_illegal",  32'(ILLEGAL), 32'd0);
    chk("rst_retired",  32'(RETIRED), 32'd0);
    @(negedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("rst_exit_state", 32'(STATE),    32'd1);
    chk("rst_exit_ctrl",  32'(dut_ctrl), 32'(exp_ctrl(4'd1, 1'b0, 1'b0, 3'd0)));
    ret_model = '0;
  endtask

  // monitor
  initial begin
    item_t cur;
    bit    active = 0;
    int    idx    = 0;
    logic [3:0] s;
    forever begin
      @(negedge CLK);
      if (!active && q.size() > 0) begin
        cur    = q.pop_front();
        idx    = 0;
        active = 1;
      end
      if (active) begin
        s = cur.st[idx*4 +: 4];
        chk("state",   32'(STATE),    32'(s));
        chk("ctrl",    32'(dut_ctrl), 32'(exp_ctrl(s, cur.mr[idx], cur.zero, cur.f3)));
        chk("illegal", 32'(ILLEGAL),  32'(s == 4'd15));
        chk("retired", 32'(RETIRED),  32'(cur.ret));
        idx++;
        if (idx == cur.len) active = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // driver
  initial begin
    item_t it;
    RST = 1'b1; OPCODE = '0; FUNCT3 = '0; ZERO = 1'b0; MEM_READY = 1'b0;
    #3;
    chk("init_state",   32'(STATE),    32'd0);
    chk("init_ctrl",    32'(dut_ctrl), 32'd0);
    chk("init_retired", 32'(RETIRED),  32'd0);
    chk("init_illegal", 32'(ILLEGAL),  32'd0);
    @(negedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("first_fetch", 32'(STATE), 32'd1);

    // directed: LW with 2 fetch stalls and 3 read stalls -> 10 cycles
    it = build(2, 2, 3, 0);
    chk("lw_latency", 32'(it.len), 32'd10);
    run_item(it, 1);
    // directed: BEQ/BNE with both ZERO values
    for (int c = 4; c <= 5; c++)
      for (int z = 0; z <= 1; z++) begin
        it = build(c, 0, 0, 0);
        it.zero = 1'(z);
        run_item(it, 1);
      end

    repeat (60) begin
      it = build($urandom_range(0, 5), $urandom_range(0, 2), $urandom_range(0, 3), 0);
      run_item(it, 1);
    end

    // reset in the middle of an instruction
    repeat (3) begin
      it = build($urandom_range(0, 5), $urandom_range(0, 2), $urandom_range(0, 3), 0);
      it.len = $urandom_range(1, it.len - 1);
      run_item(it, 0);
      do_reset();
    end

    repeat (20) begin
      it = build($urandom_range(0, 5), $urandom_range(0, 2), $urandom_range(0, 3), 0);
      run_item(it, 1);
    end

    // illegal opcodes, then reset clears ILLEGAL
    repeat (3) begin
      it = build(6, $urandom_range(0, 2), 0, $urandom_range(2, 6));
      run_item(it, 0);
      do_reset();
    end

    // 17 back-to-back ADDs from reset: counter wraps 15->0 and ends at 1
    repeat (17) begin
      it = build(0, 0, 0, 0);
      it.op = OP_R;
      it.f3 = 3'b000;
      run_item(it, 1);
    end
    chk("retired_wrap", 32'(RETIRED), 32'd1);
    MEM_READY = 1'b0;

    repeat (2) @(negedge CLK);
    chk("scoreboard_drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
